// File: rtl/cpu_io_bus.sv
// cpu_io_bus: bus stage behind the 8-bit CPU memory port.
// Accesses below IO_BASE go to the external asynchronous memory. Accesses
// at or above IO_BASE reach a small I/O register file: GPIO, a UART
// transmitter with a TX FIFO, and a free-running timer with a compare flag.
// Read data is combinational because the CPU samples din on the same edge
// that it presents the address.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_write/read/address/dout   CPU memory port (read has no side effects)
//   cpu_din                       combinational read data to the CPU
//   mem_we/addr/wdata, mem_rdata  pass-through to program/data memory
//   gpio_out, gpio_in             GPIO output latch / async GPIO inputs
//   uart_tx                       8N1 serial output, idle high, registered
//   irq                           timer compare flag
module cpu_io_bus #(
  parameter logic [7:0] IO_BASE    = 8'hF0,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_write,
  input  logic       cpu_read,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] gpio_out,
  input  logic [7:0] gpio_in,
  output logic       uart_tx,
  output logic       irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Reads carry no side effects, so the read strobe is not needed.
  logic unused_rd;
  assign unused_rd = cpu_read;

  // ---------------- decode ----------------
  logic       is_io, io_wr;
  logic [7:0] off;
  assign is_io     = cpu_address >= IO_BASE;
  assign off       = cpu_address - IO_BASE;
  assign io_wr     = cpu_write && is_io;
  assign mem_we    = cpu_write && !is_io;
  assign mem_addr  = cpu_address;
  assign mem_wdata = cpu_dout;

  // ---------------- GPIO ----------------
  logic [7:0] gpio_s1, gpio_s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
    end else begin
      if (io_wr && off == 8'h00) gpio_out <= cpu_dout;
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
    end
  end

  // ---------------- timer ----------------
  logic [7:0] tmr, tmr_cmp;
  logic       tmr_flag;
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= '0;
      tmr_cmp  <= 8'hFF;
      tmr_flag <= 1'b0;
    end else begin
      tmr <= (io_wr && off == 8'h04) ? cpu_dout : tmr + 8'd1;
      if (io_wr && off == 8'h05) tmr_cmp <= cpu_dout;
      // A match on the same edge as a clearing write keeps the flag set.
      if (tmr == tmr_cmp)                tmr_flag <= 1'b1;
      else if (io_wr && off == 8'h06)    tmr_flag <= 1'b0;
    end
  end
  assign irq = tmr_flag;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full  = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push  = io_wr && off == 8'h02 && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- UART shifter ----------------
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;
  uart_st_t      st, st_n;
  logic [DW-1:0] btmr, btmr_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, bit_end;

  assign bit_end = btmr == DIV_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      btmr    <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      st      <= st_n;
      btmr    <= btmr_n;
      bitcnt  <= bitcnt_n;
      shreg   <= shreg_n;
      uart_tx <= tx_n;
    end
  end

  // tx_n is the line level for the state being entered, so the registered
  // uart_tx lines up exactly with the shifter state.
  always_comb begin
    st_n     = st;
    btmr_n   = btmr + DW'(1);
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    tx_n     = uart_tx;
    pop      = 1'b0;
    case (st)
      IDLE: begin
        btmr_n = '0;
        tx_n   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rptr];
          st_n    = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          st_n     = DATA;
          btmr_n   = '0;
          bitcnt_n = '0;
          tx_n     = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          btmr_n = '0;
          if (bitcnt == 3'd7) begin
            st_n = STOP;
            tx_n = 1'b1;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
            shreg_n  = {1'b0, shreg[7:1]};
            tx_n     = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          btmr_n = '0;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shreg_n = fifo_mem[rptr];
            st_n    = START;
            tx_n    = 1'b0;
          end else begin
            st_n = IDLE;
            tx_n = 1'b1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // ---------------- read mux ----------------
  logic [7:0] io_rd;
  always_comb begin
    io_rd = '0;
    case (off)
      8'h00: io_rd = gpio_out;
      8'h01: io_rd = gpio_s2;
      8'h03: io_rd = {5'd0, st != IDLE, empty, full};
      8'h04: io_rd = tmr;
      8'h05: io_rd = tmr_cmp;
      8'h06: io_rd = {7'd0, tmr_flag};
      default: io_rd = '0;
    endcase
  end
  assign cpu_din = is_io ? io_rd : mem_rdata;
endmodule

// File: tb/tb_cpu_io_bus.sv
module tb_cpu_io_bus;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0, rst = 1'b1, cpu_write = 1'b0, cpu_read = 1'b0;
  logic [7:0] cpu_address = '0, cpu_dout = '0, mem_rdata = '0, gpio_in = '0;
  logic [7:0] cpu_din, mem_addr, mem_wdata, gpio_out;
  logic       mem_we, uart_tx, irq;

  cpu_io_bus #(.IO_BASE(8'hF0), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_address(cpu_address), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Behavioural reference: registers as plain values, the TX FIFO as a
  // queue and the transmitter as "byte in flight + cycles left in frame".
  logic [7:0] m_gout = 0, m_s1 = 0, m_s2 = 0, m_tmr = 0, m_cmp = 8'hFF, m_cur = 0;
  logic       m_flag = 0;
  logic [7:0] m_q[$];
  int         m_left = 0, m_pos = 0;

  function automatic logic exp_tx();
    int idx;
    if (m_left == 0) return 1'b1;
    idx = m_pos / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_stat();
    return {5'd0, m_left > 0, m_q.size() == 0, m_q.size() == DEPTH};
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    if (a < 8'hF0) return mem_rdata;
    case (a - 8'hF0)
      0: return m_gout;
      1: return m_s2;
      3: return exp_stat();
      4: return m_tmr;
      5: return m_cmp;
      6: return {7'd0, m_flag};
      default: return 8'h00;
    endcase
  endfunction

  // Advance one clock: evaluate the model on the pre-edge inputs, then
  // move to 1 time unit past the rising edge.
  task automatic step();
    logic       io;
    logic [7:0] o, gout, s1, s2, tm, cm, cur;
    logic       fl, pop;
    logic [7:0] q[$];
    int         left, pos;
    io = cpu_write && cpu_address >= 8'hF0;
    o  = cpu_address - 8'hF0;
    q = m_q; cur = m_cur; left = m_left; pos = m_pos;
    if (rst) begin
      gout = 0; s1 = 0; s2 = 0; tm = 0; cm = 8'hFF; fl = 0;
      q.delete(); left = 0; pos = 0;
    end else begin
      gout = (io && o == 0) ? cpu_dout : m_gout;
      s1 = gpio_in; s2 = m_s1;
      tm = (io && o == 4) ? cpu_dout : m_tmr + 8'd1;
      cm = (io && o == 5) ? cpu_dout : m_cmp;
      fl = (m_tmr == m_cmp) ? 1'b1 : ((io && o == 6) ? 1'b0 : m_flag);
      pop = (m_left <= 1) && (q.size() > 0);
      if (pop) begin
        cur = q.pop_front(); left = FRAME; pos = 0;
      end else if (left > 0) begin
        left--; pos++;
      end
      if (io && o == 2 && (m_q.size() < DEPTH || pop)) q.push_back(cpu_dout);
    end
    @(posedge clk); #1;
    m_gout = gout; m_s1 = s1; m_s2 = s2; m_tmr = tm; m_cmp = cm; m_flag = fl;
    m_q = q; m_cur = cur; m_left = left; m_pos = pos;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cpu_write = 1'b1; cpu_address = a; cpu_dout = d;
    step();
    cpu_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] got, output logic [7:0] exp);
    cpu_read = 1'b1; cpu_address = a;
    #1;
    got = cpu_din; exp = exp_read(a);
    cpu_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] g, e;
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_chk++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpio: got %h want 00", gpio_out); end
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(8'hF3, g, e);
    n_chk++; if (g !== 8'h02) begin n_fail++; $display("FAIL reset_stat: got %h want 02", g); end
    rd(8'hF5, g, e);
    n_chk++; if (g !== 8'hFF) begin n_fail++; $display("FAIL reset_cmp: got %h want ff", g); end
    step(); step(); step();
    rd(8'hF4, g, e);
    n_chk++; if (g !== 8'h03) begin n_fail++; $display("FAIL reset_timer_k: got %h want 03", g); end
  endtask

  task automatic test_mem_pass();
    logic [7:0] a, d, g, e;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 239)); d = 8'($urandom); mem_rdata = 8'($urandom);
      cpu_write = 1'b1; cpu_address = a; cpu_dout = d; #1;
      n_chk++; if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
        n_fail++; $display("FAIL mem_write: got we=%b a=%h d=%h want 1 %h %h", mem_we, mem_addr, mem_wdata, a, d); end
      step(); cpu_write = 1'b0;
      rd(a, g, e);
      n_chk++; if (mem_we !== 1'b0 || g !== e) begin
        n_fail++; $display("FAIL mem_read: got we=%b din=%h want 0 %h", mem_we, g, e); end
      n_chk++; if (gpio_out !== m_gout) begin n_fail++; $display("FAIL mem_no_io: gpio got %h want %h", gpio_out, m_gout); end
    end
    cpu_write = 1'b1; cpu_address = 8'hF0; cpu_dout = 8'h11; #1;
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mem_we_io: got %b want 0", mem_we); end
    cpu_write = 1'b0;
    step();
  endtask

  task automatic test_gpio();
    logic [7:0] v, gi, g, e;
    wr(8'hF0, 8'hA5);
    n_chk++; if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_out_a5: got %h want a5", gpio_out); end
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 8'h3C : 8'($urandom);
      gi = (i == 0) ? 8'h3C : 8'($urandom);
      if (i > 0) begin
        wr(8'hF0, v);
        n_chk++; if (gpio_out !== v) begin n_fail++; $display("FAIL gpio_out: got %h want %h", gpio_out, v); end
      end
      gpio_in = gi;
      for (int k = 0; k < 3; k++) begin
        rd(8'hF1, g, e);
        n_chk++; if (g !== e) begin n_fail++; $display("FAIL gpio_in_sync%0d: got %h want %h", k, g, e); end
        step();
      end
      rd(8'hF1, g, e);
      n_chk++; if (g !== gi) begin n_fail++; $display("FAIL gpio_in_final: got %h want %h", g, gi); end
    end
    v = gpio_out;
    wr(8'hF1, 8'h99); wr(8'hF3, 8'h99); wr(8'hF7, 8'h99); wr(8'h20, 8'h99);
    n_chk++; if (gpio_out !== v) begin n_fail++; $display("FAIL gpio_ro_writes: got %h want %h", gpio_out, v); end
    rd(8'hF7, g, e);
    n_chk++; if (g !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h want 00", g); end
    rd(8'hFF, g, e);
    n_chk++; if (g !== 8'h00) begin n_fail++; $display("FAIL unmapped_ff: got %h want 00", g); end
  endtask

  task automatic test_timer();
    logic [7:0] g, e;
    wr(8'hF5, 8'h10);
    wr(8'hF4, 8'h0E);
    rd(8'hF4, g, e);
    n_chk++; if (g !== 8'h0E) begin n_fail++; $display("FAIL timer_load: got %h want 0e", g); end
    step();
    rd(8'hF4, g, e);
    n_chk++; if (g !== 8'h0F) begin n_fail++; $display("FAIL timer_inc: got %h want 0f", g); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++; if (irq !== m_flag) begin n_fail++; $display("FAIL timer_flag_set: got %b want %b", irq, m_flag); end
    end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_flag_up: got %b want 1", irq); end
    wr(8'hF6, 8'h00);
    rd(8'hF6, g, e);
    n_chk++; if (g !== 8'h00) begin n_fail++; $display("FAIL timer_flag_clr: got %h want 00", g); end
    for (int i = 0; i < 260; i++) begin
      step();
      if (irq !== m_flag) begin n_chk++; n_fail++; $display("FAIL timer_wrap cyc %0d: got %b want %b", i, irq, m_flag); end
    end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_reset_after_wrap: got %b want 1", irq); end
    // Clearing write on the very edge the counter matches: the flag stays set.
    wr(8'hF6, 8'h00);
    wr(8'hF4, 8'h10);
    wr(8'hF6, 8'h00);
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_set_wins: got %b want 1", irq); end
    for (int r = 0; r < 4; r++) begin
      wr(8'hF5, 8'($urandom));
      wr(8'hF4, 8'($urandom));
      if (r[0]) wr(8'hF6, 8'h00);
      for (int i = 0; i < 40; i++) begin
        step();
        if (irq !== m_flag) begin n_chk++; n_fail++; $display("FAIL timer_rand: got %b want %b", irq, m_flag); end
      end
      rd(8'hF4, g, e);
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL timer_rand_val: got %h want %h", g, e); end
    end
  endtask

  task automatic test_uart_single();
    logic [7:0] g, e, d;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h55 : 8'($urandom);
      wr(8'hF2, d);
      rd(8'hF2, g, e);
      n_chk++; if (g !== 8'h00) begin n_fail++; $display("FAIL uart_data_read: got %h want 00", g); end
      for (int c = 0; c < FRAME + 4; c++) begin
        step();
        if (uart_tx !== exp_tx()) begin n_chk++; n_fail++; $display("FAIL uart_tx cyc %0d: got %b want %b", c, uart_tx, exp_tx()); end
        rd(8'hF3, g, e);
        if (g !== e) begin n_chk++; n_fail++; $display("FAIL uart_stat cyc %0d: got %h want %h", c, g, e); end
        if (c == 20) begin
          n_chk++; if (g !== 8'h06) begin n_fail++; $display("FAIL uart_stat_busy: got %h want 06", g); end
        end
      end
      n_chk++; if (g !== 8'h02 || uart_tx !== 1'b1) begin n_fail++; $display("FAIL uart_done: stat %h tx %b want 02 1", g, uart_tx); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, e;
    int idle_gaps = 0;
    for (int t = 0; t < 6; t++) begin
      wr(8'hF2, 8'($urandom));
      rd(8'hF3, g, e);
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL b2b_push_stat %0d: got %h want %h", t, g, e); end
      if (t == 4 || t == 5) begin
        n_chk++; if (g !== 8'h05) begin n_fail++; $display("FAIL b2b_full %0d: got %h want 05", t, g); end
      end
    end
    for (int c = 0; c < 5 * FRAME; c++) begin
      if (uart_tx !== exp_tx()) begin n_chk++; n_fail++; $display("FAIL b2b_tx cyc %0d: got %b want %b", c, uart_tx, exp_tx()); end
      if (m_left == 0 && m_q.size() == 0 && c < 5 * FRAME - 10) idle_gaps++;
      step();
    end
    n_chk++; if (idle_gaps !== 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", idle_gaps); end
    rd(8'hF3, g, e);
    n_chk++; if (g !== 8'h02 || uart_tx !== 1'b1) begin n_fail++; $display("FAIL b2b_done: stat %h tx %b want 02 1", g, uart_tx); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g, e;
    wr(8'hF2, 8'h00); wr(8'hF2, 8'hC3); wr(8'hF2, 8'h81);
    for (int i = 0; i < 12; i++) step();
    n_chk++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got %b want 0", uart_tx); end
    rst = 1'b1; step(); rst = 1'b0;
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", uart_tx); end
    rd(8'hF3, g, e);
    n_chk++; if (g !== 8'h02) begin n_fail++; $display("FAIL rstmid_stat: got %h want 02", g); end
    rd(8'hF4, g, e);
    n_chk++; if (g !== 8'h00) begin n_fail++; $display("FAIL rstmid_timer: got %h want 00", g); end
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (uart_tx !== 1'b1) begin n_chk++; n_fail++; $display("FAIL rstmid_quiet cyc %0d: got %b want 1", i, uart_tx); end
    end
    rd(8'hF4, g, e);
    n_chk++; if (g !== 8'(3 * FRAME)) begin n_fail++; $display("FAIL rstmid_timer_run: got %h want %h", g, 8'(3 * FRAME)); end
  endtask

  initial begin
    test_reset();
    test_mem_pass();
    test_gpio();
    test_timer();
    test_uart_single();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
